// File: rtl/type_decode_stage_if.sv
// Fetch-to-decode bundle: fetch handshake in, decoded entry out.
// master = fetch/consumer side, slave = the decode stage.
interface type_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic            R;
    logic            I;
    logic            L;
    logic            S;
    logic            B;
    logic            J;
    logic            Jr;
    logic            lui;
    logic            aui;
    logic            illegal;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid,
        input  R, I, L, S, B, J, Jr, lui, aui, illegal,
        input  rd, rs1, rs2, funct3, funct7, instr, pc
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid,
        output R, I, L, S, B, J, Jr, lui, aui, illegal,
        output rd, rs1, rs2, funct3, funct7, instr, pc
    );
endinterface

// File: rtl/type_decode_stage.sv
// RV32I opcode-type decode stage with a two-entry skid buffer.
// Ports: clk, rst (async active-low), bus (slave: handshake, flags, fields).
module type_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic clk,
    input  logic rst,
    type_decode_stage_if.slave bus
);
    // kind bits: [9]R [8]I [7]L [6]S [5]B [4]J [3]Jr [2]lui [1]aui [0]illegal
    typedef struct packed {
        logic [9:0]      kind;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t     m_q, m_d, k_q, k_d, in_e;
    logic       m_valid_q, m_valid_d;
    logic       k_valid_q, k_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       accept, consume;
    logic [6:0] op;
    logic [9:0] in_kind;

    always_comb begin
        op      = bus.in_instr[6:0];
        in_kind = 10'b0;
        unique case (1'b1)
            op == 7'b0110011: in_kind[9] = 1'b1;
            op == 7'b0010011: in_kind[8] = 1'b1;
            op == 7'b0000011: in_kind[7] = 1'b1;
            op == 7'b0100011: in_kind[6] = 1'b1;
            op == 7'b1100011: in_kind[5] = 1'b1;
            op == 7'b1101111: in_kind[4] = 1'b1;
            op == 7'b1100111: in_kind[3] = 1'b1;
            op == 7'b0110111: in_kind[2] = 1'b1;
            op == 7'b0010111: in_kind[1] = 1'b1;
            default:          in_kind[0] = 1'b1;
        endcase
        in_e = '{kind: in_kind, instr: bus.in_instr, pc: bus.in_pc};
    end

    always_comb begin
        m_d       = m_q;
        k_d       = k_q;
        m_valid_d = m_valid_q;
        k_valid_d = k_valid_q;
        accept    = bus.in_valid & in_ready_q;
        consume   = m_valid_q & bus.out_ready;
        if (bus.flush) begin
            // only valid bits clear; data is left stale
            m_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (consume && k_valid_q) begin
            m_d       = k_q;
            m_valid_d = 1'b1;
            k_valid_d = accept;
            if (accept) k_d = in_e;
        end else if (!m_valid_q || consume) begin
            m_valid_d = accept;
            if (accept) m_d = in_e;
        end else if (accept) begin
            k_d       = in_e;
            k_valid_d = 1'b1;
        end
        in_ready_d = ~k_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q        <= '0;
            k_q        <= '0;
            m_valid_q  <= 1'b0;
            k_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            k_q        <= k_d;
            m_valid_q  <= m_valid_d;
            k_valid_q  <= k_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    logic [9:0] kind_o;

    // bubbles must present no instruction type downstream
    assign kind_o        = m_q.kind & {10{m_valid_q}};
    assign bus.out_valid = m_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.R         = kind_o[9];
    assign bus.I         = kind_o[8];
    assign bus.L         = kind_o[7];
    assign bus.S         = kind_o[6];
    assign bus.B         = kind_o[5];
    assign bus.J         = kind_o[4];
    assign bus.Jr        = kind_o[3];
    assign bus.lui       = kind_o[2];
    assign bus.aui       = kind_o[1];
    assign bus.illegal   = kind_o[0];
    assign bus.rd        = m_q.instr[11:7];
    assign bus.rs1       = m_q.instr[19:15];
    assign bus.rs2       = m_q.instr[24:20];
    assign bus.funct3    = m_q.instr[14:12];
    assign bus.funct7    = m_q.instr[31:25];
    assign bus.instr     = m_q.instr;
    assign bus.pc        = m_q.pc;
endmodule

// File: doc/type_decode_stage.md
# type_decode_stage

Registered decode stage between instruction fetch and `controlDecode`. Accepts a 32-bit RV32I instruction word and its PC over a valid/ready handshake, classifies the opcode into one-hot type flags (R, I, L, S, B, J, Jr, lui, aui), and extracts the register and function fields. Outputs are held in a two-entry skid buffer, so fetch stalls cleanly when downstream back-pressures. The type flags drive `controlDecode` directly.

## Interface
- `XLEN`, 32: width of `pc`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all buffered entries (branch/jump redirect).
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; registered; equals NOT skid_valid.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `out_valid`  out  1  decoded entry present.
- `out_ready`  in  1  downstream consumes the entry this cycle.
- `R`, `I`, `L`, `S`, `B`, `J`, `Jr`, `lui`, `aui`  out  1 each  one-hot type flags.
- `illegal`  out  1  opcode is not one of the nine above; all type flags are 0.
- `rd`, `rs1`, `rs2`  out  5 each  instr[11:7], [19:15], [24:20].
- `funct3`  out  3  instr[14:12].
- `funct7`  out  7  instr[31:25].
- `instr`, `pc`  out  32 / XLEN  pass-through of the accepted word and its PC.

## Operation
- Opcode map on instr[6:0]: 0110011→R, 0010011→I, 0000011→L, 0100011→S, 1100011→B, 1101111→J, 1100111→Jr, 0110111→lui, 0010111→aui. Any other value→illegal=1.
- Instr[1:0]≠11 is always illegal.
- Decode is combinational on the input side. The flags and fields are stored with the entry, so outputs come straight from registers.
- Storage: main register M (drives outputs) and skid register K, each with its own valid bit.
- Accept = in_valid AND in_ready.
- On accept:
  - If M is empty, or M is consumed (out_valid AND out_ready) with K empty, the entry goes to M.
  - Otherwise it goes to K.
- When M is consumed and K is valid, K moves to M. If an accept happens in the same cycle, the new entry goes to K.
- K is only written when M is held. K can never be overwritten while valid, because in_ready=0 then.
- Throughput is one instruction per cycle with out_ready held high.
- Flush has priority over accept and consume: M.valid and K.valid clear next cycle, and any concurrent input is dropped. Data registers keep their values; only valid bits clear.
- out_valid=0 forces all type flags and `illegal` to 0 at the outputs. `controlDecode` therefore sees no instruction type during bubbles.

## Timing
- Reset (rst low, asynchronous): M.valid=K.valid=0, out_valid=0, in_ready=1. All flags, illegal, fields, instr and pc are 0.
- Deassertion of rst is synchronised externally. The first accept can occur on the first rising edge after deassertion.
- Latency is 1 cycle: an input accepted at edge N appears at the outputs after edge N.
- in_ready falls the cycle after K fills. It rises the cycle after K drains into M.
- Output data stays stable while out_valid=1 and out_ready=0.
- Reset mid-operation discards both entries immediately.
- Flush with M held and K full: both entries clear, and in_ready=1 next cycle.

## Test plan
- Reset: hold rst=0, drive in_valid=1 → out_valid=0, in_ready=1, and all outputs 0 throughout.
- Opcode sweep: with out_ready=1, send 0x003100B3 (add x1,x2,x3) then one instruction of each other type → after one cycle, exactly one correct flag is set. For add: rd=1, rs1=2, rs2=3, funct3=0, funct7=0.
- Illegal: send 0x0000007F, then 0x00000000 → illegal=1 and all nine flags are 0.
- Back-pressure: stream 4 instructions with out_ready=0 → M holds #1, K holds #2, in_ready=0 from the third cycle. Raise out_ready → #1..#4 emerge in order with none lost or duplicated.
- Flush: with M and K full, assert flush and in_valid together → next cycle out_valid=0 and in_ready=1, and the flushed-cycle input never appears.
- Async reset mid-stream: pull rst low between edges while M is valid → out_valid drops without waiting for a clock edge.
